reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the register and data width.
REQ-002 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = sequential zeroing of x1..x31 after reset, 0 = no zeroing.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rs1_addr  input  5  read port 1 register index.
REQ-006 SHALL have port rs2_addr  input  5  read port 2 register index.
REQ-007 SHALL have port reg1  output  XLEN  read port 1 data, which feeds the EX-stage operand-1 register.
REQ-008 SHALL have port reg2  output  XLEN  read port 2 data, which feeds the EX-stage operand-2 register.
REQ-009 SHALL have port we  input  1  write enable from the writeback stage.
REQ-010 SHALL have port rd_addr  input  5  write register index.
REQ-011 SHALL have port rd_data  input  XLEN  write data.
REQ-012 SHALL have port dbg_addr  input  5  debug read index.
REQ-013 SHALL have port dbg_data  output  XLEN  debug read data, combinational, with no bypass.
REQ-014 SHALL have port busy  output  1  clear in progress; the hazard unit holds the fetch/decode stages while busy is 1.

Function
REQ-015 SHALL hold 31 XLEN-bit registers x1..x31; x0 SHALL NOT be stored.
REQ-016 SHALL return 0 on reg1, reg2 and dbg_data whenever the corresponding address is 0.
REQ-017 SHALL drive reg1 and reg2 combinationally from the addresses in the same cycle; there SHALL be no read latency.
REQ-018 SHALL write rd_data into x[rd_addr] at the clock edge when we=1, rd_addr!=0 and busy=0.
REQ-019 SHALL discard a write to rd_addr=0, and any write while busy=1, with no state change.
REQ-020 SHALL bypass write to read: when we=1, busy=0, rd_addr!=0 and rd_addr==rs1_addr, reg1 SHALL equal rd_data in that cycle; reg2 SHALL follow the same rule against rs2_addr.
REQ-021 SHALL apply the bypass to both ports at once when rs1_addr==rs2_addr==rd_addr.
REQ-022 SHALL implement an FSM with two states, IDLE and CLEAR, and a 5-bit clear index clr_idx.
REQ-023 SHALL, on any edge with rst=1, enter CLEAR with clr_idx=1 when CLEAR_ON_RESET=1, or enter IDLE when CLEAR_ON_RESET=0.
REQ-024 SHALL, in CLEAR with rst=0, write 0 to x[clr_idx] and increment clr_idx on each edge.
REQ-025 SHALL, in CLEAR with clr_idx=31 and rst=0, clear x31 and move to IDLE on that edge; clr_idx SHALL NOT wrap.
REQ-026 SHALL perform no clearing while rst remains 1; the 31-cycle sweep SHALL start on the first edge after rst falls.
REQ-027 SHALL drive busy=1 while the FSM is in CLEAR or rst=1, and busy=0 otherwise.
REQ-028 SHALL force reg1, reg2 and dbg_data to 0 while busy=1.
REQ-029 SHALL restart the sweep at clr_idx=1 if rst is asserted during CLEAR.
REQ-030 SHALL let rst assertion during IDLE abort any same-cycle write.

Reset
REQ-031 SHALL, after rst, show the following output values: busy=1; reg1=reg2=dbg_data=0.
REQ-032 SHALL, with CLEAR_ON_RESET=1, hold busy=1 for exactly 31 cycles after rst deasserts, and then read every register as 0.
REQ-033 SHALL, with CLEAR_ON_RESET=0, drop busy the cycle after rst deasserts and leave register contents unchanged by reset.

Verification
REQ-034 Reset clear: rst=1 for 2 cycles, then 0 -> busy=1 for 31 cycles; afterwards reading x1..x31 gives 0x00000000.
REQ-035 Write/read: we=1, rd_addr=5, rd_data=0xDEADBEEF; next cycle rs1_addr=5 -> reg1=0xDEADBEEF; rs2_addr=0 -> reg2=0.
REQ-036 Bypass: we=1, rd_addr=7, rd_data=0x12345678, rs1_addr=rs2_addr=7 in the same cycle -> reg1=reg2=0x12345678 in that cycle.
REQ-037 x0 protection: we=1, rd_addr=0, rd_data=0xFFFFFFFF -> rs1_addr=0 gives 0, dbg_addr=0 gives 0, and no other register changes.
REQ-038 Busy discard: write x3=0xA5A5A5A5 during clear cycle 10 -> after busy falls, x3 reads 0 and reg1 read 0 while busy was 1.
REQ-039 Mid-clear reset: rst=1 at clear cycle 15, then 0 -> busy stays 1 a further 31 cycles after rst falls, and all registers read 0.

Source files
------------

// File: rtl/reg_file.sv
// Integer register file x1..x31 with two bypassed read ports and a debug port.
// After reset, an optional sweep zeroes x1..x31 one register per cycle while busy is high.
module reg_file #(
    parameter int XLEN           = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] reg1,
    output logic [XLEN-1:0] reg2,
    input  logic            we,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic            busy
);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t          state;
    logic [4:0]      clr_idx;
    logic            clearing;
    logic [XLEN-1:0] x [31:1];
    logic            wr_ok;

    // FSM state and clear index; rst restarts the sweep from x1 at any time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clr_idx  <= 5'd1;
            clearing <= CLEAR_ON_RESET;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_idx == 5'd31) begin
                        state    <= IDLE;
                        clearing <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + 5'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    clearing <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = clearing | rst;
    assign wr_ok = we && !busy && (rd_addr != 5'd0);

    // Storage has no reset; the sweep (or the writeback port) is the only writer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                x[clr_idx] <= '0;
            else if (wr_ok)
                x[rd_addr] <= rd_data;
        end
    end

    always_comb begin
        reg1     = '0;
        reg2     = '0;
        dbg_data = '0;
        if (!busy) begin
            if (rs1_addr != 5'd0)
                reg1 = (wr_ok && rd_addr == rs1_addr) ? rd_data : x[rs1_addr];
            if (rs2_addr != 5'd0)
                reg2 = (wr_ok && rd_addr == rs2_addr) ? rd_data : x[rs2_addr];
            if (dbg_addr != 5'd0)
                dbg_data = x[dbg_addr];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed-vector bench for reg_file: clear sweep timing, read/write, bypass, x0, busy discard.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
    logic [31:0] reg1, reg2, rd_data, dbg_data;
    logic        we, busy;

    int n_vec = 0;
    int n_err = 0;
    int n;

    reg_file #(.XLEN(32), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .reg1(reg1), .reg2(reg2),
        .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen in the same slot.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles (up to stop_at); optionally tries a write to x3 at cycle wr_at.
    task automatic count_busy(input int wr_at, input int stop_at, output int cnt);
        cnt = 0;
        while (busy && cnt < stop_at) begin
            if (cnt == wr_at) begin
                we = 1'b1; rd_addr = 5'd3; rd_data = 32'hA5A5_A5A5; rs1_addr = 5'd3;
                #1;
                chk("reg1_while_busy", reg1, 32'h0);
            end
            tick();
            we = 1'b0;
            cnt++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 1; i < 32; i++) begin
            dbg_addr = i[4:0];
            #1;
            chk(tag, dbg_data, 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; rd_addr = '0; rd_data = '0;
        rs1_addr = 5'd1; rs2_addr = 5'd2; dbg_addr = 5'd1;

        // Reset state
        tick();
        chk("rst_busy", {31'b0, busy}, 32'h1);
        chk("rst_reg1", reg1, 32'h0);
        chk("rst_reg2", reg2, 32'h0);
        chk("rst_dbg", dbg_data, 32'h0);
        tick();
        rst = 1'b0;

        // Sweep length, with a discarded write to x3 at clear cycle 10
        count_busy(10, 200, n);
        chk("clear_len", n, 32'd31);
        check_all_zero("clear_zero");
        dbg_addr = 5'd3; #1;
        chk("x3_discarded", dbg_data, 32'h0);

        // Write then read
        we = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEAD_BEEF;
        tick();
        we = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd0; #1;
        chk("rd_x5", reg1, 32'hDEAD_BEEF);
        chk("rd_x0_p2", reg2, 32'h0);

        // Bypass on both ports; debug port sees the stored (old) value
        we = 1'b1; rd_addr = 5'd7; rd_data = 32'h1234_5678;
        rs1_addr = 5'd7; rs2_addr = 5'd7; dbg_addr = 5'd7; #1;
        chk("byp_reg1", reg1, 32'h1234_5678);
        chk("byp_reg2", reg2, 32'h1234_5678);
        chk("dbg_nobyp", dbg_data, 32'h0);
        rs2_addr = 5'd5; #1;
        chk("nobyp_reg2", reg2, 32'hDEAD_BEEF);
        tick();
        we = 1'b0; #1;
        chk("x7_stored", dbg_data, 32'h1234_5678);

        // x0 protection
        we = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFF_FFFF; rs1_addr = 5'd0; #1;
        chk("x0_byp", reg1, 32'h0);
        tick();
        we = 1'b0; dbg_addr = 5'd0; #1;
        chk("x0_rd1", reg1, 32'h0);
        chk("x0_dbg", dbg_data, 32'h0);
        dbg_addr = 5'd5; #1;
        chk("x0_x5", dbg_data, 32'hDEAD_BEEF);
        dbg_addr = 5'd1; #1;
        chk("x0_x1", dbg_data, 32'h0);

        // Fill every register with a distinct nonzero value
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; rd_addr = i[4:0]; rd_data = 32'h1000_0000 + i;
            tick();
        end
        we = 1'b0;
        dbg_addr = 5'd31; #1;
        chk("fill_x31", dbg_data, 32'h1000_001F);
        rs1_addr = 5'd20; #1;
        chk("fill_x20", reg1, 32'h1000_0014);

        // Reset in IDLE with a same-cycle write, then mid-sweep reset at clear cycle 15
        rst = 1'b1; we = 1'b1; rd_addr = 5'd9; rd_data = 32'h0BAD_0BAD; #1;
        chk("rst_rd1", reg1, 32'h0);
        tick();
        we = 1'b0; rst = 1'b0;
        count_busy(-1, 15, n);
        chk("mid_cnt", n, 32'd15);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", {31'b0, busy}, 32'h1);
        rst = 1'b0;
        count_busy(-1, 200, n);
        chk("mid_clear_len", n, 32'd31);
        check_all_zero("mid_zero");
        chk("idle_busy", {31'b0, busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
